reg_dump_streamer: RTL and testbench

- Sits directly downstream of the RISC-V datapath top (`main`) and consumes its 32 architectural register outputs (x0..x31).
- On a `start` request, it snapshots all registers in one cycle.
- It then streams the snapshot as (index, value) beats over a valid/ready interface, for use by a debug UART, trace FIFO or bench monitor.
- The snapshot makes the dump atomic, even while the datapath keeps executing.

---
 rtl/reg_dump_streamer.sv | 115 +++++++++++
 tb/tb_reg_dump_streamer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_streamer
// Function : Atomically snapshots NREGS architectural registers on start and
//            streams them as (index, value) beats over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_streamer #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int IDXW  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NREGS*XLEN-1:0] regs_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDXW-1:0]       out_idx,
    output logic [XLEN-1:0]       out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] C_LAST = IDXW'(NREGS - 1);

    state_t          r_state;
    logic [IDXW-1:0] r_count;
    logic [XLEN-1:0] r_snap [NREGS];

    logic [IDXW-1:0] w_next;
    logic            w_xfer;

    assign w_next = r_count + IDXW'(1);
    assign w_xfer = out_valid & out_ready;

    // Snapshot has no reset: its contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            for (int i = 0; i < NREGS; i++) begin
                r_snap[i] <= regs_flat[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // First beat comes straight from the live inputs, which
                        // equal what is being captured into the snapshot now.
                        r_state   <= S_STREAM;
                        r_count   <= '0;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        out_data  <= regs_flat[XLEN-1:0];
                        out_last  <= (C_LAST == '0);
                        busy      <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        if (r_count == C_LAST) begin
                            r_state   <= S_DONE;
                            r_count   <= '0;
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            r_count  <= w_next;
                            out_idx  <= w_next;
                            out_data <= r_snap[w_next];
                            out_last <= (w_next == C_LAST);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_count   <= '0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_streamer
// Function : Self-checking bench for reg_dump_streamer (vector tables plus
//            hand-written reset and back-to-back sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_streamer;

    localparam int NREGS = 32;
    localparam int XLEN  = 32;
    localparam int IDXW  = 5;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [NREGS*XLEN-1:0] regs_flat;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDXW-1:0]       out_idx;
    logic [XLEN-1:0]       out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    reg_dump_streamer #(.NREGS(NREGS), .XLEN(XLEN), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .regs_flat (regs_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle: inputs driven this cycle, outputs expected this cycle.
    typedef struct {
        logic        rdy;
        logic        st;
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int vec, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %h expected %h", name, vec, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int kind, input int k);
        case (kind)
            0:       return 32'h1000_0000 + 32'(k);
            1:       return ~32'(k);
            2:       return 32'hAAAA_AAAA;
            default: return 32'hC000_0000 + 32'(k);
        endcase
    endfunction

    task automatic set_regs(input int kind);
        for (int i = 0; i < NREGS; i++) regs_flat[i*XLEN +: XLEN] = pat(kind, i);
    endtask

    // Expected stream from the cycle after the start edge: rpat 0 = ready always,
    // rpat 1 = ready 1,0,0,1,0,0,...; busy_starts pulses start at beat 5 and in DONE.
    task automatic build(input int kind, input int rpat, input bit busy_starts);
        vec_t v;
        int   k = 0;
        int   c = 0;
        tbl.delete();
        while (k < NREGS) begin
            v.valid = 1'b1;
            v.idx   = 5'(k);
            v.data  = pat(kind, k);
            v.last  = (k == NREGS - 1);
            v.busy  = 1'b1;
            v.done  = 1'b0;
            v.rdy   = (rpat == 0) ? 1'b1 : ((c % 3) == 0);
            v.st    = busy_starts && (k == 5);
            tbl.push_back(v);
            if (v.rdy) k++;
            c++;
        end
        v = '{rdy: 1'b1, st: busy_starts, valid: 1'b0, idx: 5'd0, data: 32'd0,
              last: 1'b0, busy: 1'b1, done: 1'b1};
        tbl.push_back(v);
        v = '{rdy: 1'b1, st: 1'b0, valid: 1'b0, idx: 5'd0, data: 32'd0,
              last: 1'b0, busy: 1'b0, done: 1'b0};
        tbl.push_back(v);
        tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            check({name, ".valid"}, i, 32'(out_valid), 32'(tbl[i].valid));
            check({name, ".busy"},  i, 32'(busy),      32'(tbl[i].busy));
            check({name, ".done"},  i, 32'(done),      32'(tbl[i].done));
            if (tbl[i].valid) begin
                check({name, ".idx"},  i, 32'(out_idx),  32'(tbl[i].idx));
                check({name, ".data"}, i, out_data,      tbl[i].data);
                check({name, ".last"}, i, 32'(out_last), 32'(tbl[i].last));
            end
            out_ready = tbl[i].rdy;
            start     = tbl[i].st;
            step();
        end
        start = 1'b0;
    endtask

    task automatic kick(input int kind);
        set_regs(kind);
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int ndone;
        int nidle;
        bit prev;
        bit seen;

        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        regs_flat = '0;
        repeat (3) step();
        rst = 1'b0;
        check("reset.valid", 0, 32'(out_valid), 32'd0);
        check("reset.idx",   0, 32'(out_idx),   32'd0);
        check("reset.data",  0, out_data,       32'd0);
        check("reset.last",  0, 32'(out_last),  32'd0);
        check("reset.busy",  0, 32'(busy),      32'd0);
        check("reset.done",  0, 32'(done),      32'd0);
        step();

        kick(0);
        build(0, 0, 1'b0);
        run_table("basic");

        kick(1);
        build(1, 1, 1'b0);
        run_table("bp");

        kick(2);
        for (int i = 0; i < NREGS; i++) regs_flat[i*XLEN +: XLEN] = 32'h5555_5555;
        build(2, 0, 1'b0);
        run_table("iso");

        kick(0);
        build(0, 0, 1'b1);
        run_table("busystart");

        // Reset while beat 10 is pending and stalled.
        kick(1);
        repeat (10) step();
        check("rst.pre_idx",   0, 32'(out_idx),   32'd10);
        check("rst.pre_valid", 0, 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rst.valid", i, 32'(out_valid), 32'd0);
            check("rst.busy",  i, 32'(busy),      32'd0);
            check("rst.done",  i, 32'(done),      32'd0);
            step();
        end
        kick(3);
        build(3, 0, 1'b0);
        run_table("restart");

        // start held high: 32 beats, 1 DONE, 1 IDLE, so first beats are 34
        // cycles apart (35 edges counting the original start edge).
        kick(0);
        start = 1'b1;
        cyc   = 0;
        ndone = 0;
        nidle = 0;
        prev  = 1'b1;
        check("b2b.first_valid", 0, 32'(out_valid), 32'd1);
        while (cyc < 100) begin
            step();
            cyc++;
            if (done) ndone++;
            if (!busy) nidle++;
            if (out_valid && !prev) break;
            prev = out_valid;
        end
        check("b2b.period",    0, 32'(cyc),      32'd34);
        check("b2b.done_cnt",  0, 32'(ndone),    32'd1);
        check("b2b.idle_cnt",  0, 32'(nidle),    32'd1);
        check("b2b.idx0",      0, 32'(out_idx),  32'd0);
        check("b2b.data0",     0, out_data,      pat(0, 0));
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        check("b2b.second_done", 0, 32'(seen), 32'd1);
        step();
        check("b2b.final_busy", 0, 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
